// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter.
//   OVERSAMPLE       : clk cycles per bit = prescale * OVERSAMPLE
//   PRESCALE_CNT_W   : width of the bit-timing down counter
//   rx_state_t       : receiver frame state
//   bit_reload()     : counter reload for one full bit period
//   half_reload()    : counter reload from start edge to start-bit centre
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE      = 8;
    localparam int OVERSAMPLE_LOG2 = $clog2(OVERSAMPLE);
    localparam int PRESCALE_CNT_W  = 19;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic [PRESCALE_CNT_W-1:0] prescale_ext(input logic [15:0] p);
        return {{(PRESCALE_CNT_W-16){1'b0}}, p};
    endfunction

    // Full bit period: counter runs (P*8)-1 .. 0, i.e. P*8 cycles.
    function automatic logic [PRESCALE_CNT_W-1:0] bit_reload(input logic [15:0] p);
        return (prescale_ext(p) << OVERSAMPLE_LOG2) - PRESCALE_CNT_W'(1);
    endfunction

    // Half a bit period, shortened by the cycles already spent detecting the
    // edge, so the start-bit check lands on its centre.
    function automatic logic [PRESCALE_CNT_W-1:0] half_reload(input logic [15:0] p);
        return (prescale_ext(p) << (OVERSAMPLE_LOG2 - 1)) - PRESCALE_CNT_W'(2);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// 1 (line idle) so that reset release never looks like a start bit.
//   clk     : clock
//   rst     : synchronous reset, active-high
//   async_i : asynchronous input
//   sync_o  : synchronized output
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: flops are written with non-blocking assignments so every register
    // samples the pre-edge value of its source; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit, no
// parity. Bits are sampled at their centres using a down counter running at
// prescale*8 clk cycles per bit. Received words are presented on an
// AXI-stream master port.
//   clk, rst       : clock, synchronous active-high reset
//   m_axis_tdata   : received word
//   m_axis_tvalid  : word valid, held until m_axis_tready
//   m_axis_tready  : downstream accept
//   rxd            : asynchronous serial input, idle high
//   busy           : frame reception in progress
//   overrun_error  : one-cycle pulse, a new word replaced an unaccepted one
//   frame_error    : one-cycle pulse, stop bit sampled low
//   prescale       : bit period = prescale*8 clk cycles (0 disables reception)
// Build option: define UART_RX_MAJORITY_EN to make every start/data/stop
// decision a 2-of-3 vote over the samples at counter values 2, 1 and 0.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    logic                      rxd_s;
    logic                      rx_bit;

    rx_state_t                 state_q, state_d;
    logic [PRESCALE_CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]     tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d;
    logic                      overrun_q, overrun_d;
    logic                      frame_q, frame_d;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (rxd),
        .sync_o  (rxd_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic samp2_q;
    logic samp1_q;

    // Capture the two samples preceding each decision point; the third vote
    // is rxd_s itself at the decision cycle, so timing is unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp2_q <= 1'b1;
            samp1_q <= 1'b1;
        end else begin
            if (cnt_q == PRESCALE_CNT_W'(2)) samp2_q <= rxd_s;
            if (cnt_q == PRESCALE_CNT_W'(1)) samp1_q <= rxd_s;
        end
    end

    assign rx_bit = (samp2_q & samp1_q) | (samp2_q & rxd_s) | (samp1_q & rxd_s);
`else
    assign rx_bit = rxd_s;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tdata_d   = tdata_q;
        // A completed handshake drops tvalid unless a new word lands below.
        tvalid_d  = tvalid_q && !m_axis_tready;
        overrun_d = 1'b0;
        frame_d   = 1'b0;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - PRESCALE_CNT_W'(1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (prescale != 16'd0 && !rxd_s) begin
                        cnt_d   = half_reload(prescale);
                        state_d = START;
                    end
                end
                START: begin
                    if (!rx_bit) begin
                        cnt_d     = bit_reload(prescale);
                        bit_cnt_d = 4'(DATA_WIDTH);
                        state_d   = DATA;
                    end else begin
                        // Line went back high before the centre: a glitch.
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    shreg_d   = {rx_bit, shreg_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    cnt_d     = bit_reload(prescale);
                    if (bit_cnt_q == 4'd1) state_d = STOP;
                end
                STOP: begin
                    if (rx_bit) begin
                        tdata_d   = shreg_q;
                        tvalid_d  = 1'b1;
                        overrun_d = tvalid_q && !m_axis_tready;
                        state_d   = IDLE;
                    end else begin
                        frame_d = 1'b1;
                        state_d = BREAK;
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a long low
                    // level is not re-read as a train of start bits.
                    if (rxd_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the shift register and output word are reset along with the
        // control state because their reset values are visible on the ports;
        // a large storage array would normally be left unreset.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign overrun_error = overrun_q;
    assign frame_error   = frame_q;
    assign busy          = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule
